// File: rtl/conv_window_stream_if.sv
// Pixel-in / window-out stream bundle for the sliding-window generator.
// master drives pixels and accepts windows; slave is the window generator.
interface conv_window_stream_if #(
  parameter int BIT_DEPTH = 8,
  parameter int K         = 3
);
  logic                       in_valid;
  logic                       in_ready;
  logic [BIT_DEPTH-1:0]       in_data;
  logic                       win_valid;
  logic                       win_ready;
  logic [K*K*BIT_DEPTH-1:0]   win_data;
  logic [7:0]                 win_row;
  logic [7:0]                 win_col;

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_row, win_col
  );

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, win_row, win_col
  );
endinterface

// File: rtl/conv_window_stream.sv
// Streaming KxK sliding-window generator: raster pixels in, strided windows out.
// Windows leave one cycle after the pixel that completes them is accepted.
//
//   state | meaning
//   IDLE  | waiting for start, no pixels accepted
//   RUN   | accepting pixels, emitting qualifying windows
//   DRAIN | last pixel taken, waiting for final window to be consumed
module conv_window_stream #(
  parameter int BIT_DEPTH = 8,
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int K         = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [1:0]          stride_i,
  output logic                busy_o,
  output logic                done_o,
  conv_window_stream_if.slave s_if
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int WW = K * K * BIT_DEPTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        stride_q, stride_d;
  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic [1:0]        cp_q, cp_d;
  logic [1:0]        rp_q, rp_d;
  logic [CW-1:0]     ocol_q, ocol_d;
  logic [RW-1:0]     orow_q, orow_d;
  logic              win_valid_q, win_valid_d;
  logic [WW-1:0]     win_data_q, win_data_d;
  logic [7:0]        win_row_q, win_row_d;
  logic [7:0]        win_col_q, win_col_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              in_ready;
  logic              accept;
  logic              col_ok;
  logic              row_ok;
  logic              qualify;

  // lb_q[0] holds the previous row, lb_q[K-2] the oldest row still needed.
  logic [BIT_DEPTH-1:0] lb_q      [K-1][COLS];
  logic [BIT_DEPTH-1:0] win_reg_q [K][K];
  logic [BIT_DEPTH-1:0] win_next  [K][K];
  logic [BIT_DEPTH-1:0] col_v     [K];
  logic [WW-1:0]        win_next_flat;

  assign col_ok  = (c_q >= CW'(K-1));
  assign row_ok  = (r_q >= RW'(K-1));
  assign qualify = col_ok && row_ok && (cp_q == 2'd0) && (rp_q == 2'd0);

  always_comb begin
    for (int i = 0; i < K-1; i++) begin
      col_v[i] = lb_q[K-2-i][c_q];
    end
    col_v[K-1] = s_if.in_data;
  end

  // Window as it will look after the current pixel shifts in from the right.
  always_comb begin
    win_next_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K-1; j++) begin
        win_next[i][j] = win_reg_q[i][j+1];
      end
      win_next[i][K-1] = col_v[i];
    end
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_next_flat[(i*K+j)*BIT_DEPTH +: BIT_DEPTH] = win_next[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][c_q] <= s_if.in_data;
      for (int k = 1; k < K-1; k++) begin
        lb_q[k][c_q] <= lb_q[k-1][c_q];
      end
      win_reg_q <= win_next;
    end
  end

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    c_d         = c_q;
    r_d         = r_q;
    cp_d        = cp_q;
    rp_d        = rp_q;
    ocol_d      = ocol_q;
    orow_d      = orow_q;
    win_valid_d = win_valid_q & ~s_if.win_ready;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          stride_d = (stride_i == 2'd0) ? 2'd1 : stride_i;
          c_d      = '0;
          r_d      = '0;
          cp_d     = 2'd0;
          rp_d     = 2'd0;
          ocol_d   = '0;
          orow_d   = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end

      RUN: begin
        in_ready = ~win_valid_q | s_if.win_ready;
        accept   = in_ready & s_if.in_valid;
        if (accept) begin
          if (qualify) begin
            win_valid_d = 1'b1;
            win_data_d  = win_next_flat;
            win_row_d   = 8'(orow_q);
            win_col_d   = 8'(ocol_q);
          end
          // Phase counters replace a divide/modulo by the runtime stride.
          if (col_ok) begin
            cp_d = (cp_q == stride_q - 2'd1) ? 2'd0 : cp_q + 2'd1;
            if (cp_q == 2'd0) begin
              ocol_d = ocol_q + 1'b1;
            end
          end
          if (c_q == CW'(COLS-1)) begin
            c_d    = '0;
            cp_d   = 2'd0;
            ocol_d = '0;
            if (row_ok) begin
              rp_d = (rp_q == stride_q - 2'd1) ? 2'd0 : rp_q + 2'd1;
              if (rp_q == 2'd0) begin
                orow_d = orow_q + 1'b1;
              end
            end
            if (r_q == RW'(ROWS-1)) begin
              r_d     = '0;
              state_d = DRAIN;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (!(win_valid_q && !s_if.win_ready)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stride_q    <= 2'd1;
      c_q         <= '0;
      r_q         <= '0;
      cp_q        <= 2'd0;
      rp_q        <= 2'd0;
      ocol_q      <= '0;
      orow_q      <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      c_q         <= c_d;
      r_q         <= r_d;
      cp_q        <= cp_d;
      rp_q        <= rp_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_if.in_ready  = in_ready;
  assign s_if.win_valid = win_valid_q;
  assign s_if.win_data  = win_data_q;
  assign s_if.win_row   = win_row_q;
  assign s_if.win_col   = win_col_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: doc/conv_window_stream.md
Name: conv_window_stream

Overview:
- Streaming KxK sliding-window generator for the convolution datapath.
- Next generation of the fixed 3x3, 28-column line-buffer front end: kernel size, image height/width and stride are all parametrised.
- Pixels arrive through a valid/ready input stream. Complete windows leave through a valid/ready output stream to the MAC array.
- start/done frame control matches the existing convolution top.

Parameters:
- BIT_DEPTH, 8, bits per pixel.
- COLS, 28, image width in pixels (>= K).
- ROWS, 28, image height in pixels (>= K).
- K, 3, kernel edge length (2..7).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle frame start pulse; ignored unless idle.
- stride  input  2  window step, 1..3; sampled on start; 0 is treated as 1.
- in_valid  input  1  pixel valid.
- in_ready  output  1  block accepts a pixel this cycle.
- in_data  input  BIT_DEPTH  pixel, raster order (row-major, top-left first).
- win_valid  output  1  window output valid.
- win_ready  input  1  downstream accepts the window.
- win_data  output  K*K*BIT_DEPTH  window; element (i,j) at bits [(i*K+j)*BIT_DEPTH +: BIT_DEPTH]; i=0 is the top (oldest) row, j=0 the leftmost column.
- win_row  output  8  output-map row index of the current window.
- win_col  output  8  output-map column index of the current window.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, rst=0) drives these outputs and registers to 0: in_ready, win_valid, win_data, win_row, win_col, busy, done; state=IDLE; row/col counters=0. Line-buffer contents are don't-care.
- State IDLE:
  - On start: latch stride (0->1), clear the counters, go to RUN, busy=1.
- State RUN:
  - in_ready = !win_valid | win_ready.
  - A pixel is accepted when in_valid & in_ready.
  - Each accepted pixel shifts into K-1 line buffers of depth COLS and a KxK register window.
  - Input counters: col r_c 0..COLS-1, row r_r 0..ROWS-1, with wrap at COLS.
- Window emission: when the accepted pixel is at (r_r, r_c) and all of the following hold, the next cycle sets win_valid=1 and loads win_data, win_row=(r_r-(K-1))/stride, win_col=(r_c-(K-1))/stride:
  - r_r >= K-1
  - r_c >= K-1
  - (r_r-(K-1)) mod stride == 0
  - (r_c-(K-1)) mod stride == 0
- Latency: exactly 1 cycle from the accepting edge to win_valid.
- Output hold: win_valid stays high and win_data/win_row/win_col hold until win_valid & win_ready. The same cycle may load a new window if a qualifying pixel is accepted.
- Output map size: OH=(ROWS-K)/stride+1, OW=(COLS-K)/stride+1 (floor division). Trailing pixels beyond the last full step are consumed but produce no window.
- When pixel (ROWS-1, COLS-1) is accepted, move to DRAIN.
  - in_ready=0 in DRAIN.
  - Stay in DRAIN until no window is pending.
  - Then go to IDLE and pulse done for 1 cycle. busy falls in the same cycle.
- start while busy: ignored, no effect on counters or stride.
- Stride change mid-frame: no effect; the latched value is used.
- Reset mid-frame: immediate abort to the reset state. A later start begins a fresh frame.
- Counter widths: $clog2 of COLS and ROWS. win_row/win_col are zero-extended to 8 bits.

Test Plan:
- stride=1, ramp input pixel=(r*28+c)%256, win_ready=1, in_valid=1:
  - Exactly 676 windows, done once after the last.
  - First window = {0,1,2,28,29,30,56,57,58} at (0,0).
  - Last window at (25,25).
- stride=2, same ramp:
  - 169 windows.
  - Window (0,1) top row = {2,3,4}.
  - Window (1,0) top-left = 56.
  - Last window at (12,12).
- stride=3:
  - 81 windows; last window at (8,8), top-left = 24*28+24 = 696%256 = 184.
  - Pixels in column 27 and row 27 produce no window.
  - stride=0 gives results identical to stride=1.
- Backpressure: hold win_ready=0 for 5 cycles when the first window appears:
  - win_data/win_row/win_col stay stable.
  - in_ready=0 while a window is pending.
  - No pixel is lost; 676 windows total.
- Random in_valid gaps (50% duty) plus random win_ready:
  - Window sequence bit-identical to the gap-free stride=1 run.
- Edge cases:
  - Assert rst=0 after 300 accepted pixels: all outputs 0 immediately; a new start with stride=2 completes with 169 windows.
  - start pulsed mid-frame: ignored, window count unchanged.
